// File: rtl/ipdc_pkg.sv
// Shared definitions for the ipdc initiator: op-mode encodings, host FSM states,
// pixel width and the display-mode classifier.
package ipdc_pkg;

   localparam int PIX_W = 24;

   localparam logic [2:0] OP_LOAD    = 3'd0;
   localparam logic [2:0] OP_RSHIFT  = 3'd1;
   localparam logic [2:0] OP_DSHIFT  = 3'd2;
   localparam logic [2:0] OP_DEFAULT = 3'd3;
   localparam logic [2:0] OP_ZOOM    = 3'd4;
   localparam logic [2:0] OP_MEDIAN  = 3'd5;
   localparam logic [2:0] OP_YCBCR   = 3'd6;
   localparam logic [2:0] OP_RGB     = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_LOAD      = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_COLLECT   = 3'd4
   } host_state_e;

   // Display-producing ops answer with a pixel window rather than a done pulse.
   function automatic logic is_display(input logic [2:0] mode);
      logic r;
      case (mode)
         OP_RSHIFT, OP_DSHIFT, OP_DEFAULT, OP_ZOOM: r = 1'b1;
         default:                                   r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ipdc_host_watchdog.sv
// Idle-cycle watchdog for ipdc_host; only instantiated when IPDC_HOST_TIMEOUT_EN is defined.
module ipdc_host_watchdog
   import ipdc_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_active,
   input  logic i_kick,
   output logic o_expire
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Expiry fires on the last idle cycle so the host leaves on that same edge.
   assign o_expire = i_active && !i_kick && (cnt_q == CW'(TIMEOUT_CYC - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (!i_active || i_kick || o_expire) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ipdc_host.sv
// Initiator-side driver for ipdc: issues ops, streams image loads, collects responses.
// Optional abort watchdog enabled by defining IPDC_HOST_TIMEOUT_EN.
module ipdc_host
   import ipdc_pkg::*;
#(
   parameter int PIX_COUNT = 64,
   parameter int WIN_COUNT = 16
`ifdef IPDC_HOST_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 1024
`endif
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_cmd_valid,
   input  logic [2:0]       i_cmd_mode,
   output logic             o_cmd_ready,
   input  logic             i_pix_valid,
   input  logic [PIX_W-1:0] i_pix_data,
   output logic             o_pix_ready,
   output logic             o_op_valid,
   output logic [2:0]       o_op_mode,
   output logic             o_in_valid,
   output logic [PIX_W-1:0] o_in_data,
   input  logic             i_in_ready,
   input  logic             i_out_valid,
   input  logic [PIX_W-1:0] i_out_data,
   output logic             o_res_valid,
   output logic [PIX_W-1:0] o_res_data,
   output logic             o_res_last,
   output logic             o_done,
   output logic             o_timeout
);

   host_state_e      state_q, state_d;
   logic [2:0]       mode_q, mode_d;
   logic [6:0]       pix_cnt_q, pix_cnt_d;
   logic [4:0]       beat_cnt_q, beat_cnt_d;
   logic             res_valid_q, res_valid_d;
   logic [PIX_W-1:0] res_data_q, res_data_d;
   logic             res_last_q, res_last_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
   logic             xfer_s;
   logic             expire_s;

   assign xfer_s = (state_q == ST_LOAD) && i_pix_valid && i_in_ready;

`ifdef IPDC_HOST_TIMEOUT_EN
   ipdc_host_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_active ((state_q == ST_LOAD) || (state_q == ST_WAIT_DONE) || (state_q == ST_COLLECT)),
      .i_kick   (xfer_s || i_out_valid),
      .o_expire (expire_s)
   );
`else
   assign expire_s = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      pix_cnt_d   = pix_cnt_q;
      beat_cnt_d  = beat_cnt_q;
      res_valid_d = 1'b0;
      res_data_d  = res_data_q;
      res_last_d  = 1'b0;
      done_d      = 1'b0;
      timeout_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_cmd_valid) begin
               mode_d  = i_cmd_mode;
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            case (mode_q)
               OP_LOAD:                    state_d = ST_LOAD;
               OP_MEDIAN, OP_YCBCR, OP_RGB: state_d = ST_WAIT_DONE;
               default:                    state_d = is_display(mode_q) ? ST_COLLECT : ST_WAIT_DONE;
            endcase
         end
         ST_LOAD: begin
            if (xfer_s && (pix_cnt_q == 7'(PIX_COUNT - 1))) begin
               pix_cnt_d = 7'd0;
               state_d   = ST_WAIT_DONE;
            end else if (xfer_s) begin
               pix_cnt_d = pix_cnt_q + 7'd1;
            end else begin
               pix_cnt_d = pix_cnt_q;
            end
         end
         ST_WAIT_DONE: begin
            if (i_out_valid) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_DONE;
            end
         end
         ST_COLLECT: begin
            if (i_out_valid) begin
               res_valid_d = 1'b1;
               res_data_d  = i_out_data;
               if (beat_cnt_q == 5'(WIN_COUNT - 1)) begin
                  res_last_d = 1'b1;
                  done_d     = 1'b1;
                  beat_cnt_d = 5'd0;
                  state_d    = ST_IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + 5'd1;
               end
            end else begin
               state_d = ST_COLLECT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // An abort discards any partial load or window without a done pulse.
      if (expire_s) begin
         timeout_d   = 1'b1;
         pix_cnt_d   = 7'd0;
         beat_cnt_d  = 5'd0;
         res_valid_d = 1'b0;
         res_last_d  = 1'b0;
         done_d      = 1'b0;
         state_d     = ST_IDLE;
      end else begin
         timeout_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         mode_q      <= 3'd0;
         pix_cnt_q   <= 7'd0;
         beat_cnt_q  <= 5'd0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_last_q  <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         pix_cnt_q   <= pix_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_last_q  <= res_last_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
      end
   end

   assign o_cmd_ready = (state_q == ST_IDLE);
   assign o_op_valid  = (state_q == ST_ISSUE);
   assign o_op_mode   = (state_q == ST_ISSUE) ? mode_q : 3'd0;
   assign o_in_valid  = (state_q == ST_LOAD) && i_pix_valid;
   assign o_in_data   = (state_q == ST_LOAD) ? i_pix_data : '0;
   assign o_pix_ready = (state_q == ST_LOAD) && i_in_ready;
   assign o_res_valid = res_valid_q;
   assign o_res_data  = res_data_q;
   assign o_res_last  = res_last_q;
   assign o_done      = done_q;
   assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_ipdc_host.sv
// Directed self-checking bench for ipdc_host (timeout scenario built with IPDC_HOST_TIMEOUT_EN).
module tb_ipdc_host;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic [2:0]  cmd_mode;
   logic        cmd_ready;
   logic        pix_valid;
   logic [23:0] pix_data;
   logic        pix_ready;
   logic        op_valid;
   logic [2:0]  op_mode;
   logic        in_valid;
   logic [23:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [23:0] out_data;
   logic        res_valid;
   logic [23:0] res_data;
   logic        res_last;
   logic        done;
   logic        timeout;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ipdc_host #(
      .PIX_COUNT (64),
      .WIN_COUNT (16)
`ifdef IPDC_HOST_TIMEOUT_EN
      ,
      .TIMEOUT_CYC (8)
`endif
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_cmd_valid (cmd_valid),
      .i_cmd_mode  (cmd_mode),
      .o_cmd_ready (cmd_ready),
      .i_pix_valid (pix_valid),
      .i_pix_data  (pix_data),
      .o_pix_ready (pix_ready),
      .o_op_valid  (op_valid),
      .o_op_mode   (op_mode),
      .o_in_valid  (in_valid),
      .o_in_data   (in_data),
      .i_in_ready  (in_ready),
      .i_out_valid (out_valid),
      .i_out_data  (out_data),
      .o_res_valid (res_valid),
      .o_res_data  (res_data),
      .o_res_last  (res_last),
      .o_done      (done),
      .o_timeout   (timeout)
   );

   // Accept a command from IDLE; returns what was seen during the ISSUE cycle.
   task automatic issue_cmd(input logic [2:0] m, output logic ov, output logic [2:0] om,
                            output logic rdy);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_mode  = m;
      @(negedge clk);
      ov  = op_valid;
      om  = op_mode;
      rdy = cmd_ready;
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 3'd0; pix_valid = 1'b0; pix_data = '0;
      in_ready = 1'b0; out_valid = 1'b0; out_data = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
      checks++;
      if ({op_valid, op_mode, in_valid, in_data, pix_ready, res_valid, res_data, res_last, done, timeout} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got op=%b/%0d in=%b/%h prdy=%b res=%b/%h last=%b done=%b to=%b want all 0",
                  op_valid, op_mode, in_valid, in_data, pix_ready, res_valid, res_data, res_last, done, timeout);
      end
   endtask

   // Stream 64 pixels; stall=1 drops in_ready every 3rd and pix_valid every 5th cycle.
   task automatic test_load(input bit stall, input int skip_issue_check);
      logic ov, rdy; logic [2:0] om;
      int xfers = 0, cyc = 0, bad = 0, dones = 0;
      issue_cmd(3'd0, ov, om, rdy);
      if (skip_issue_check == 0) begin
         checks++;
         if (ov !== 1'b1 || om !== 3'd0 || rdy !== 1'b0) begin
            errors++; $display("FAIL load_issue got op_valid=%b mode=%0d ready=%b want 1/0/0", ov, om, rdy);
         end
      end
      while (xfers < 64 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         pix_valid = stall ? (cyc % 5 != 0) : 1'b1;
         in_ready  = stall ? (cyc % 3 != 0) : 1'b1;
         pix_data  = 24'(xfers);
         #1;
         if (in_valid !== pix_valid || pix_ready !== in_ready || in_data !== pix_data) bad++;
         if (done !== 1'b0) dones++;
         if (pix_valid && in_ready) xfers++;
      end
      checks++;
      if (bad != 0 || xfers != 64) begin
         errors++; $display("FAIL load_stream got bad_beats=%0d transfers=%0d want 0/64", bad, xfers);
      end
      if (!stall) begin
         checks++;
         if (cyc != 64) begin errors++; $display("FAIL load_throughput got %0d cycles want 64", cyc); end
      end
      // First WAIT_DONE cycle: source still offers a pixel, which must not pass through.
      @(negedge clk);
      pix_valid = 1'b1; pix_data = 24'h123456; in_ready = 1'b1;
      #1;
      checks++;
      if (in_valid !== 1'b0 || pix_ready !== 1'b0 || dones != 0) begin
         errors++; $display("FAIL load_end got in_valid=%b pix_ready=%b early_done=%0d want 0/0/0",
                            in_valid, pix_ready, dones);
      end
      pix_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      out_valid = 1'b1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL load_done_early got %b want 0", done); end
      @(negedge clk);
      out_valid = 1'b0;
      checks++;
      if (done !== 1'b1 || cmd_ready !== 1'b1) begin
         errors++; $display("FAIL load_done got done=%b ready=%b want 1/1", done, cmd_ready);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL load_done_pulse got %b want 0", done); end
   endtask

   task automatic test_zoom;
      logic ov, rdy; logic [2:0] om;
      int bad = 0;
      issue_cmd(3'd4, ov, om, rdy);
      checks++;
      if (ov !== 1'b1 || om !== 3'd4) begin
         errors++; $display("FAIL zoom_issue got op_valid=%b mode=%0d want 1/4", ov, om);
      end
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (k == 0) begin
            if (res_valid !== 1'b0) bad++;
         end else begin
            if (res_valid !== 1'b1 || res_data !== 24'hA00000 + 24'(k - 1) || res_last !== 1'b0 || done !== 1'b0) bad++;
         end
         out_valid = 1'b1;
         out_data  = 24'hA00000 + 24'(k);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL zoom_window got %0d bad beats want 0", bad); end
      @(negedge clk);
      out_data = 24'hBEEF00;
      checks++;
      if (res_valid !== 1'b1 || res_data !== 24'hA0000F || res_last !== 1'b1 || done !== 1'b1) begin
         errors++; $display("FAIL zoom_last got v=%b d=%h last=%b done=%b want 1/a0000f/1/1",
                            res_valid, res_data, res_last, done);
      end
      @(negedge clk);
      out_valid = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || res_last !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++; $display("FAIL zoom_extra_beat got v=%b last=%b done=%b ready=%b want 0/0/0/1",
                            res_valid, res_last, done, cmd_ready);
      end
   endtask

   task automatic test_ycbcr;
      logic ov, rdy; logic [2:0] om;
      int stray = 0;
      @(negedge clk);
      out_valid = 1'b1;
      @(negedge clk);
      out_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || res_valid !== 1'b0) begin
         errors++; $display("FAIL idle_out_valid got done=%b res_valid=%b want 0/0", done, res_valid);
      end
      issue_cmd(3'd6, ov, om, rdy);
      checks++;
      if (ov !== 1'b1 || om !== 3'd6) begin
         errors++; $display("FAIL ycbcr_issue got op_valid=%b mode=%0d want 1/6", ov, om);
      end
      repeat (2) begin
         @(negedge clk);
         if (done !== 1'b0 || res_valid !== 1'b0 || timeout !== 1'b0) stray++;
      end
      out_valid = 1'b1;
      @(negedge clk);
      out_valid = 1'b0;
      checks++;
      if (done !== 1'b1 || res_valid !== 1'b0 || stray != 0) begin
         errors++; $display("FAIL ycbcr_done got done=%b res_valid=%b stray=%0d want 1/0/0", done, res_valid, stray);
      end
   endtask

   task automatic test_reset_mid_load;
      logic ov, rdy; logic [2:0] om;
      issue_cmd(3'd0, ov, om, rdy);
      for (int k = 0; k < 21; k++) begin
         @(negedge clk);
         pix_valid = 1'b1; in_ready = 1'b1; pix_data = 24'(k);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || {op_valid, op_mode, in_valid, in_data, pix_ready, res_valid, res_data, res_last, done, timeout} !== '0) begin
         errors++; $display("FAIL mid_load_reset got ready=%b in_valid=%b pix_ready=%b op=%b want 1/0/0/0",
                            cmd_ready, in_valid, pix_ready, op_valid);
      end
      pix_valid = 1'b0;
      test_load(1'b0, 0);
   endtask

`ifdef IPDC_HOST_TIMEOUT_EN
   task automatic test_timeout;
      logic ov, rdy; logic [2:0] om;
      int n = 0, dones = 0;
      issue_cmd(3'd5, ov, om, rdy);
      while (timeout !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
         if (done !== 1'b0) dones++;
      end
      checks++;
      if (n != 9 || dones != 0) begin
         errors++; $display("FAIL timeout_pulse got cycle=%0d dones=%0d want 9/0", n, dones);
      end
      @(negedge clk);
      checks++;
      if (timeout !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++; $display("FAIL timeout_single got to=%b ready=%b want 0/1", timeout, cmd_ready);
      end
      issue_cmd(3'd7, ov, om, rdy);
      checks++;
      if (ov !== 1'b1 || om !== 3'd7) begin
         errors++; $display("FAIL timeout_next_cmd got op_valid=%b mode=%0d want 1/7", ov, om);
      end
      @(negedge clk);
      out_valid = 1'b1;
      @(negedge clk);
      out_valid = 1'b0;
   endtask
`endif

   initial begin
      test_reset;
      test_load(1'b0, 0);
      test_load(1'b1, 0);
      test_zoom;
      test_ycbcr;
      test_reset_mid_load;
`ifdef IPDC_HOST_TIMEOUT_EN
      test_timeout;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
